// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780-class LCD: power-up delay, init commands, then a full
// 34-byte screen rewrite whenever either row buffer differs from its snapshot.
module lcd_frame_writer #(
  parameter int unsigned POWERUP_CYCLES = 1_000_000,
  parameter int unsigned EN_CYCLES      = 10,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned CLEAR_CYCLES   = 20_000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned ROW_W  = 128;
  localparam int unsigned BW     = 6;
  localparam int unsigned MAX_A  = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
  localparam int unsigned MAX_B  = (GAP_CYCLES > CLEAR_CYCLES) ? GAP_CYCLES : CLEAR_CYCLES;
  localparam int unsigned MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW     = $clog2(MAX_P + 1);
  localparam logic [BW-1:0] INIT_LAST  = 6'd3;
  localparam logic [BW-1:0] FRAME_LAST = 6'd33;
  localparam logic [BW-1:0] CLEAR_IDX  = 6'd2;

  typedef enum logic [1:0] {S_POWERUP, S_INIT, S_IDLE, S_FRAME} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_GAP} phase_t;

  state_t            state, state_d;
  phase_t            phase, phase_d;
  logic [CW-1:0]     dly, dly_d, gap_len;
  logic [BW-1:0]     byte_idx, byte_d;
  logic [ROW_W-1:0]  snap_top, snap_top_d, snap_bottom, snap_bottom_d;
  logic              last_byte;
  logic              lcd_en_d, lcd_rs_d, busy_d, frame_done_d;
  logic [7:0]        lcd_data_d;

  // Column 0 lives in the top byte; NUL is shown as a space.
  function automatic logic [7:0] char_at(input logic [ROW_W-1:0] row, input logic [3:0] col);
    logic [3:0] rc;
    logic [7:0] ch;
    rc = 4'd15 - col;
    ch = row[{rc, 3'b000} +: 8];
    return (ch == 8'h00) ? 8'h20 : ch;
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= S_POWERUP;
      phase       <= PH_SETUP;
      dly         <= '0;
      byte_idx    <= '0;
      snap_top    <= '0;
      snap_bottom <= '0;
      lcd_en      <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      dly         <= dly_d;
      byte_idx    <= byte_d;
      snap_top    <= snap_top_d;
      snap_bottom <= snap_bottom_d;
      lcd_en      <= lcd_en_d;
      lcd_rs      <= lcd_rs_d;
      lcd_data    <= lcd_data_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
    end
  end

  // Next-state sequencing: POWERUP delay, then setup/enable/gap phases per byte.
  always_comb begin
    state_d       = state;
    phase_d       = phase;
    dly_d         = dly;
    byte_d        = byte_idx;
    snap_top_d    = snap_top;
    snap_bottom_d = snap_bottom;
    gap_len       = (state == S_INIT && byte_idx == CLEAR_IDX) ? CW'(CLEAR_CYCLES) : CW'(GAP_CYCLES);
    last_byte     = (state == S_INIT) ? (byte_idx == INIT_LAST) : (byte_idx == FRAME_LAST);
    case (state)
      S_POWERUP: begin
        if (dly == CW'(POWERUP_CYCLES - 1)) begin
          state_d = S_INIT;
          phase_d = PH_SETUP;
          dly_d   = '0;
          byte_d  = '0;
        end else begin
          dly_d = dly + CW'(1);
        end
      end
      S_IDLE: begin
        if ({top, bottom} != {snap_top, snap_bottom}) begin
          state_d       = S_FRAME;
          phase_d       = PH_SETUP;
          dly_d         = '0;
          byte_d        = '0;
          snap_top_d    = top;
          snap_bottom_d = bottom;
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_d = PH_EN;
            dly_d   = '0;
          end
          PH_EN: begin
            if (dly == CW'(EN_CYCLES - 1)) begin
              phase_d = PH_GAP;
              dly_d   = '0;
            end else begin
              dly_d = dly + CW'(1);
            end
          end
          default: begin
            if (dly == gap_len - CW'(1)) begin
              phase_d = PH_SETUP;
              dly_d   = '0;
              if (!last_byte) begin
                byte_d = byte_idx + 6'd1;
              end else if (state == S_INIT) begin
                state_d       = S_FRAME;
                byte_d        = '0;
                snap_top_d    = top;
                snap_bottom_d = bottom;
              end else begin
                state_d = S_IDLE;
                byte_d  = '0;
              end
            end else begin
              dly_d = dly + CW'(1);
            end
          end
        endcase
      end
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state.
  always_comb begin
    lcd_en_d     = 1'b0;
    lcd_rs_d     = 1'b0;
    lcd_data_d   = 8'h00;
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_FRAME) && (byte_d == FRAME_LAST) &&
                   (phase_d == PH_GAP) && (dly_d == CW'(GAP_CYCLES - 1));
    if (state_d == S_INIT) begin
      lcd_en_d   = (phase_d == PH_EN);
      lcd_data_d = init_byte(byte_d[1:0]);
    end else if (state_d == S_FRAME) begin
      lcd_en_d = (phase_d == PH_EN);
      if (byte_d == 6'd0) begin
        lcd_data_d = 8'h80;
      end else if (byte_d <= 6'd16) begin
        lcd_rs_d   = 1'b1;
        lcd_data_d = char_at(snap_top_d, 4'(byte_d - 6'd1));
      end else if (byte_d == 6'd17) begin
        lcd_data_d = 8'hC0;
      end else begin
        lcd_rs_d   = 1'b1;
        lcd_data_d = char_at(snap_bottom_d, 4'(byte_d - 6'd18));
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: scoreboard of expected LCD bytes plus table of
// row-buffer vectors and hand-written sequences for init, mid-frame change and reset.
module tb_lcd_frame_writer;

  logic         clk = 1'b0;
  logic         nRst;
  logic [127:0] top, bottom;
  logic         lcd_en, lcd_rs, lcd_rw, busy, frame_done;
  logic [7:0]   lcd_data;

  lcd_frame_writer #(
    .POWERUP_CYCLES(8), .EN_CYCLES(2), .GAP_CYCLES(3), .CLEAR_CYCLES(6)
  ) dut (
    .clk(clk), .nRst(nRst), .top(top), .bottom(bottom),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] top;
    logic [127:0] bottom;
    logic [127:0] exp_top;
    logic [127:0] exp_bottom;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb[$];
  int         rise_cyc[$];
  int         cyc = 0;
  int         en_len = 0;
  int         nbytes = 0;
  logic       prev_en = 1'b0;
  logic [8:0] cap = '0;
  logic [8:0] e_byte;
  bit         unstable = 1'b0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  // Bus monitor: each rising enable delivers one byte to the scoreboard.
  always @(negedge clk) begin
    if (!nRst) begin
      cyc = 0;
      prev_en = 1'b0;
      en_len = 0;
      rise_cyc.delete();
      sb.delete();
    end else begin
      cyc++;
      if (lcd_en) begin
        if (!prev_en) begin
          cap = {lcd_rs, lcd_data};
          en_len = 1;
          unstable = 1'b0;
          nbytes++;
          rise_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h, expected none", cap);
          end else begin
            e_byte = sb.pop_front();
            chk($sformatf("lcd_byte#%0d", nbytes), 32'(cap), 32'(e_byte));
          end
        end else begin
          en_len++;
          if ({lcd_rs, lcd_data} !== cap) unstable = 1'b1;
        end
      end else if (prev_en) begin
        chk("en_high_cycles", 32'(en_len), 32'd2);
        chk("bus_hold_during_en", 32'(unstable), 32'd0);
      end
      prev_en = lcd_en;
    end
  end

  task automatic push_frame(input logic [127:0] et, input logic [127:0] eb);
    logic [127:0] t, b;
    t = et;
    b = eb;
    sb.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++) sb.push_back({1'b1, t[127-8*c -: 8]});
    sb.push_back({1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) sb.push_back({1'b1, b[127-8*c -: 8]});
  endtask

  // Releases reset and checks the power-up hold, init byte timing and first frame setup.
  task automatic release_and_check(input logic [127:0] et, input logic [127:0] eb);
    int bad;
    int want_rise[4];
    want_rise = '{9, 15, 21, 30};
    @(negedge clk);
    #2;
    nRst = 1'b1;
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
    push_frame(et, eb);
    bad = 0;
    if (busy !== 1'b1 || lcd_en !== 1'b0) bad++;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || lcd_en !== 1'b0) bad++;
    end
    chk("powerup_hold", 32'(bad), 32'd0);
    @(negedge clk);
    chk("init_first_setup", {22'd0, lcd_en, lcd_rs, lcd_data}, {22'd0, 2'b00, 8'h38});
    repeat (27) @(negedge clk);
    chk("first_frame_setup_c35", {21'd0, busy, lcd_en, lcd_rs, lcd_data}, {21'd0, 3'b100, 8'h80});
    chk("init_rise_count", 32'(rise_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rise_cyc.size()) chk("init_rise_cycle", 32'(rise_cyc[i]), 32'(want_rise[i]));
    end
  endtask

  // Waits (bounded) from a frame's setup cycle to frame_done and checks busy falls next.
  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) break;
    end
    chk({name, "_frame_len"}, 32'(n), 32'd203);
    @(negedge clk);
    chk({name, "_busy_fall"}, {30'd0, busy, frame_done}, 32'd0);
  endtask

  task automatic drive_and_setup(input logic [127:0] t, input logic [127:0] b, input string name);
    @(negedge clk);
    top = t;
    bottom = b;
    @(negedge clk);
    chk({name, "_setup"}, {21'd0, busy, lcd_en, lcd_rs, lcd_data}, {21'd0, 3'b100, 8'h80});
  endtask

  vec_t vecs[4];
  logic [127:0] mid_top, old_bot, new_bot, rst_top, rst_bot;

  initial begin
    int base, guard, bad;
    vecs[0] = '{{"    Win", 72'h0}, 128'h0, {"    Win", {9{8'h20}}}, {16{8'h20}}};
    vecs[1] = '{{"    Win", 64'h0, 8'h5F}, 128'h0, {"    Win", {8{8'h20}}, 8'h5F}, {16{8'h20}}};
    vecs[2] = '{"HELLO WORLD!1234", "abcdefghijklmnop", "HELLO WORLD!1234", "abcdefghijklmnop"};
    vecs[3] = '{128'h00FF7E41_00012000_00000000_00000042, 128'h31323334_35363738_39300000_00000000,
                128'h20FF7E41_20012020_20202020_20202042, 128'h31323334_35363738_39302020_20202020};
    mid_top = "MIDFRAME TEST   ";
    old_bot = "old bottom row  ";
    new_bot = "NEW BOTTOM ROW!!";
    rst_top = "RESET IN FRAME  ";
    rst_bot = {16{8'h5A}};

    nRst = 1'b1;
    top = vecs[0].top;
    bottom = vecs[0].bottom;
    #1 nRst = 1'b0;
    #3;
    chk("reset_outputs", {26'd0, lcd_en, lcd_rs, lcd_rw, busy, frame_done, 1'b0}, {26'd0, 6'b000100});
    chk("reset_data", 32'(lcd_data), 32'h00);

    release_and_check(vecs[0].exp_top, vecs[0].exp_bottom);
    finish_frame("init_frame");

    for (int i = 1; i < 4; i++) begin
      push_frame(vecs[i].exp_top, vecs[i].exp_bottom);
      drive_and_setup(vecs[i].top, vecs[i].bottom, $sformatf("vec%0d", i));
      finish_frame($sformatf("vec%0d", i));
    end

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (lcd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("no_change_idle", 32'(bad), 32'd0);

    push_frame(mid_top, old_bot);
    base = nbytes;
    drive_and_setup(mid_top, old_bot, "midframe");
    guard = 0;
    while (nbytes < base + 10 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_byte10", 32'(nbytes >= base + 10), 32'd1);
    bottom = new_bot;
    push_frame(mid_top, new_bot);
    guard = 0;
    while (frame_done !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("midframe_first_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("midframe_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("refresh_setup", {21'd0, busy, lcd_en, lcd_rs, lcd_data}, {21'd0, 3'b100, 8'h80});
    finish_frame("refresh");

    push_frame(rst_top, rst_bot);
    base = nbytes;
    drive_and_setup(rst_top, rst_bot, "rstframe");
    guard = 0;
    while (!(nbytes >= base + 20 && lcd_en === 1'b1) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_reset_en", {30'd0, lcd_en, lcd_rs}, {30'd0, 2'b11});
    #1 nRst = 1'b0;
    #1;
    chk("async_reset_pins", {21'd0, lcd_en, lcd_rs, lcd_data, busy}, {21'd0, 10'd0, 1'b1});
    release_and_check(rst_top, rst_bot);
    finish_frame("post_reset");
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Sequencer that drives the host's 16x2 HD44780-class character LCD from the two 128-bit row buffers produced by the host display logic. The row buffers are named `top` and `bottom`; each holds 16 ASCII bytes, and bits [127:120] are the leftmost character. After reset the block runs the LCD power-up and initialisation sequence. From then on it rewrites the whole screen each time either row buffer changes. It sits between the host display logic and the LCD pins, and owns all LCD bus timing.

## Interface
- POWERUP_CYCLES, 1_000_000 — idle cycles after reset release before the first command.
- EN_CYCLES, 10 — cycles `lcd_en` is held high per byte.
- GAP_CYCLES, 500 — cycles `lcd_en` is held low after each byte; data and RS are held during these cycles.
- CLEAR_CYCLES, 20_000 — replaces GAP_CYCLES after the clear command (0x01).
- clk  input  1  system clock.
- nRst  input  1  asynchronous, active-low reset.
- top  input  128  row 0 characters; [127:120] is column 0.
- bottom  input  128  row 1 characters; same ordering as `top`.
- lcd_en  output  1  LCD enable strobe.
- lcd_rs  output  1  0 = command byte, 1 = data byte.
- lcd_rw  output  1  tied to 0 (write only).
- lcd_data  output  8  LCD data bus.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of a frame write.

## Operation
- States:
  - POWERUP: counts POWERUP_CYCLES.
  - INIT: sends 0x38, 0x0C, 0x01, 0x06 in that order, all with RS=0.
  - IDLE.
  - FRAME: sends 34 bytes.
- FRAME byte order:
  - cmd 0x80 (RS=0).
  - 16 data bytes of the `top` snapshot, column 0 first (RS=1).
  - cmd 0xC0 (RS=0).
  - 16 data bytes of the `bottom` snapshot (RS=1).
- Byte 0x00 in a snapshot is sent as 0x20 (space). All other values pass unchanged.
- Snapshot: on entry to FRAME, `top` and `bottom` are registered into snap_top and snap_bottom. Input changes during a frame never affect that frame.
- Transitions:
  - POWERUP→INIT when the count expires.
  - INIT→FRAME after the 4th byte. The first frame after init is unconditional.
  - FRAME→IDLE after byte 34.
  - IDLE→FRAME when `{top,bottom} != {snap_top,snap_bottom}`.
- A change that arrives during a frame is caught by the IDLE comparison. The next frame starts on the cycle after the current frame returns to IDLE.
- Byte counter and character index are sized to hold 0..33. Delay counter is sized to hold the largest parameter; no wrap is permitted within a phase.
- Reset mid-operation (async): every output returns to its reset value immediately. The sequence restarts from POWERUP with the full power-up delay, and snapshots are cleared to 0.

## Timing
- Reset values:
  - `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00.
  - `busy`=1, `frame_done`=0.
  - state=POWERUP.
- Per byte, cycle-level:
  - 1 setup cycle: `lcd_en`=0, `lcd_rs` and `lcd_data` valid.
  - EN_CYCLES cycles with `lcd_en`=1.
  - GAP_CYCLES cycles with `lcd_en`=0, or CLEAR_CYCLES after 0x01.
  - `lcd_rs` and `lcd_data` stay stable for the entire byte window.
- Byte period is 1+EN_CYCLES+GAP_CYCLES. Frame length is 34×(1+EN_CYCLES+GAP_CYCLES) cycles.
- `frame_done` is high on the final gap cycle of byte 34. `busy` falls on the following cycle.
- IDLE→FRAME: the first setup cycle occurs 1 cycle after the mismatch is seen. The snapshot is taken on that same edge.
- All outputs are registered; no combinational path exists from `top`/`bottom` to the pins.

## Test plan
Test parameters: POWERUP_CYCLES=8, EN_CYCLES=2, GAP_CYCLES=3, CLEAR_CYCLES=6.

1. Init sequence:
   - Stimulus: release reset.
   - Required: `busy`=1, `lcd_en`=0 for 8 cycles. Then bytes 0x38, 0x0C, 0x01, 0x06 with RS=0, each with exactly 2 `lcd_en`-high cycles. The gap after 0x01 is 6 cycles. The first frame setup cycle follows 35 cycles after reset release.
2. Full frame:
   - Stimulus: `top` = "    Win" padded, `bottom` = 0.
   - Required: 0x80, then 16 top bytes in column order, 0xC0, then 16× 0x20. Frame takes 204 cycles, `frame_done` pulses once, `busy` drops.
3. Change while IDLE:
   - Stimulus: flip `top`[7:0] from 0x00 to 0x5F.
   - Required: setup cycle of 0x80 one cycle later. Column 15 of row 0 is sent as 0x5F.
4. Change mid-frame:
   - Stimulus: alter `bottom` at frame byte 10.
   - Required: the current frame sends old `bottom` data. `busy` drops for 1 cycle, then a second frame sends the new data.
5. No change:
   - Stimulus: hold inputs constant for 1000 cycles after a frame.
   - Required: `lcd_en` stays 0 and `busy` stays 0.
6. Reset mid-frame:
   - Stimulus: assert `nRst` during byte 20 while `lcd_en`=1.
   - Required: `lcd_en`, `lcd_rs`, `lcd_data` read 0 in the same cycle. After release, the full POWERUP and INIT sequence repeats exactly as in scenario 1.
